move_extractor: RTL and testbench
=================================

# move_extractor

Sits between the UART packet receiver and `game_fsm`. It takes each received 162-bit board packet and compares it cell-by-cell against the local board, one cell per clock. It then reports either a single legal placement on `move_avail`/`move` or a classified packet error. It replaces "accept whole remote board" with "accept one validated move".

## Interface
Parameters:
- `CELLS`, 81, board cells (9x9, index = row*9 + col).
- `PKT_LEN`, 162, bus width = 2*CELLS; cell i occupies bits [2i+1:2i].

Ports:
- `clk_in` input 1: system clock (65 MHz).
- `rst_in` input 1: reset, asynchronous, active-low.
- `rx_ready` input 1: one-cycle pulse, `rx_bus` valid.
- `rx_bus` input PKT_LEN: received board.
- `board_bus` input PKT_LEN: current local board, same packing.
- `move_avail` output 1: one-cycle pulse, legal move found.
- `move` output 8: cell index 0..80 of placed stone; held until next result.
- `move_color` output 2: colour of placed stone; held.
- `pkt_err` output 1: one-cycle pulse, packet rejected.
- `err_code` output 2: 1 illegal encoding, 2 bad addition, 3 bad removal; held.
- `busy` output 1: high while a packet is being scanned.

## Operation
- Cell encoding: 00 EMPTY, 01 BLACK, 10 WHITE, 11 BAD.
- States: IDLE, SCAN, DONE.
- IDLE, `rx_ready`=1: snapshot `rx_bus` and `board_bus` into local registers, clear idx/flags, go to SCAN.
- SCAN: at idx, with old = board cell and new = rx cell:
  - new==11 → set `bad_enc`.
  - old==00, new!=00 → addition; add_cnt saturates at 2; record add_idx = idx and add_col = new.
  - old!=00, new==00 → removal; set rem_black or rem_white per old.
  - old!=00, new!=00, new!=old → set `overwrite`.
  - idx increments; at idx==80 go to DONE.
- DONE evaluates with priority bad_enc > (overwrite or add_cnt>=2 or (add_cnt==0 and any removal)) > removal of add_col colour:
  - Error → `pkt_err` pulse with `err_code` 1/2/3 respectively.
  - Exactly one addition and only opposite-colour removals → `move_avail` pulse, `move`=add_idx, `move_color`=add_col.
  - No differences → no pulse, outputs unchanged.
- Pending buffer, one entry: `rx_ready` while not IDLE stores `rx_bus` into pending (a later arrival overwrites it; latest wins).
- DONE with pending valid → load pending and live `board_bus`, go to SCAN directly; otherwise go to IDLE.
- `rx_ready` in DONE goes to pending.
- Reset (async assert): state IDLE, pending cleared, all outputs 0 (`move`=0, `move_color`=0, `err_code`=0). Mid-scan reset discards the packet and emits no result.

## Timing
- `rx_ready` sampled at edge T.
- Cells 0..80 are processed at edges T+1..T+81.
- DONE registers the result at edge T+82. `move_avail`/`pkt_err` are high for the one cycle between T+82 and T+83; the consumer samples them at T+83.
- Fixed latency is 83 cycles regardless of content.
- `busy` rises after T and falls after T+82, unless the pending packet starts immediately. In that case `busy` stays high and the next result appears 82 cycles later.
- `move_avail` and `pkt_err` are never high together.
- `board_bus` is sampled only at scan start; later changes do not affect the current scan.

## Structure
- Shared package `board_pkg`:
  - `CELLS`, `PKT_LEN`, `BOARD_N`=9.
  - `cell_t` enum (EMPTY/BLACK/WHITE/BAD).
  - `err_t` enum (NONE/ENC/ADD/REM).
  - Function `cell_at(bus, idx)` returning `cell_t`.
  - Also used by `bus_arr_converter` and `game_fsm`.
- No sub-module: a single FSM with datapath. Shift both snapshot registers right by 2 each SCAN cycle so the LSBs hold the current cell (no 81:1 mux).

## Test plan
- Empty `board_bus`; `rx_bus` cell 40 = 01 → `move_avail` at T+83, `move`=40, `move_color`=01, `pkt_err`=0.
- `board_bus` cell 0 = WHITE; `rx_bus` cell 0 = EMPTY, cell 1 = BLACK → `move`=1, `move_color`=01 (legal capture).
- `rx_bus` cell 80 = 11, plus one valid addition → `pkt_err` pulse, `err_code`=1, no `move_avail`.
- Additions at cells 3 and 5 → `err_code`=2. One BLACK addition with one BLACK removal → `err_code`=3. `rx_bus`==`board_bus` → no pulse at all.
- `rx_ready` at T, T+10, T+20 (distinct packets) → exactly two results: first packet at T+83, third packet at T+165; second packet dropped.
- `rst_in` low at T+40 of a scan → outputs 0, no pulse; next `rx_ready` after release yields the normal 83-cycle result.

Source files
------------

// File: rtl/board_pkg.sv
// Board cell encoding, error classes and bus geometry shared by the board datapath blocks.
// Latency: none (types, constants and a combinational cell accessor only).
// Backpressure: n/a.
// Contents: CELLS/PKT_LEN/BOARD_N, cell_t, err_t, cell_at(bus, idx).
package board_pkg;

    localparam int CELLS   = 81;
    localparam int PKT_LEN = 2 * CELLS;
    localparam int BOARD_N = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10,
        BAD   = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ENC  = 2'd1,
        ADD  = 2'd2,
        REM  = 2'd3
    } err_t;

    // Cell i lives in bits [2i+1:2i] of a packed board bus.
    function automatic cell_t cell_at(input logic [PKT_LEN-1:0] bus, input int idx);
        return cell_t'(bus[2*idx +: 2]);
    endfunction

endpackage

// File: rtl/move_extractor_if.sv
// Bundle between the packet receiver / game logic and move_extractor.
// Latency: none (wires only).
// Backpressure: none; rx_ready is a one-cycle pulse, results are one-cycle pulses with held payload.
// Ports: master drives rx_ready/rx_bus/board_bus; slave drives move_avail/move/move_color/pkt_err/err_code/busy.
interface move_extractor_if;
    import board_pkg::*;

    logic               rx_ready;
    logic [PKT_LEN-1:0] rx_bus;
    logic [PKT_LEN-1:0] board_bus;
    logic               move_avail;
    logic [7:0]         move;
    logic [1:0]         move_color;
    logic               pkt_err;
    logic [1:0]         err_code;
    logic               busy;

    modport master (
        output rx_ready, rx_bus, board_bus,
        input  move_avail, move, move_color, pkt_err, err_code, busy
    );

    modport slave (
        input  rx_ready, rx_bus, board_bus,
        output move_avail, move, move_color, pkt_err, err_code, busy
    );

endinterface

// File: rtl/move_extractor.sv
// Diffs a received board against the local board one cell per clock and reports one legal move or an error class.
// Latency: fixed 83 cycles from rx_ready edge to the sampled result pulse; back-to-back pending packet adds 82.
// Backpressure: none; one pending slot absorbs packets arriving mid-scan, a newer arrival replaces it.
// Ports: clk_in, rst_in (async active-low), bus (move_extractor_if.slave).
module move_extractor
    import board_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    move_extractor_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t             state;
    logic [PKT_LEN-1:0] rx_sh;
    logic [PKT_LEN-1:0] brd_sh;
    logic [PKT_LEN-1:0] pend_dat;
    logic               pend_vld;
    logic [6:0]         idx;
    logic [1:0]         add_cnt;
    logic [7:0]         add_idx;
    cell_t              add_col;
    logic               bad_enc;
    logic               overwrite;
    logic               rem_black;
    logic               rem_white;
    logic               move_avail_r;
    logic               pkt_err_r;
    logic [7:0]         move_r;
    cell_t              move_col_r;
    err_t               err_r;

    logic  start_rx;
    logic  start_pend;
    cell_t old_c;
    cell_t new_c;

    // Both snapshots shift right every scan cycle, so the current cell is always at the LSBs.
    assign old_c = cell_at(brd_sh, 0);
    assign new_c = cell_at(rx_sh, 0);

    // A fresh rx_ready in IDLE beats an older pending packet; DONE chains straight into a pending one.
    always_comb begin
        start_rx   = 1'b0;
        start_pend = 1'b0;
        if (state == S_IDLE) begin
            if (bus.rx_ready) start_rx = 1'b1;
            else if (pend_vld) start_pend = 1'b1;
        end else if (state == S_DONE && pend_vld) begin
            start_pend = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= S_IDLE;
            rx_sh        <= '0;
            brd_sh       <= '0;
            pend_dat     <= '0;
            pend_vld     <= 1'b0;
            idx          <= '0;
            add_cnt      <= '0;
            add_idx      <= '0;
            add_col      <= EMPTY;
            bad_enc      <= 1'b0;
            overwrite    <= 1'b0;
            rem_black    <= 1'b0;
            rem_white    <= 1'b0;
            move_avail_r <= 1'b0;
            pkt_err_r    <= 1'b0;
            move_r       <= '0;
            move_col_r   <= EMPTY;
            err_r        <= NONE;
        end else begin
            move_avail_r <= 1'b0;
            pkt_err_r    <= 1'b0;

            case (state)
                S_IDLE: ;
                S_SCAN: begin
                    if (new_c == BAD) bad_enc <= 1'b1;
                    if (old_c == EMPTY && new_c != EMPTY) begin
                        if (add_cnt != 2'd2) add_cnt <= add_cnt + 2'd1;
                        add_idx <= {1'b0, idx};
                        add_col <= new_c;
                    end
                    if (old_c != EMPTY && new_c == EMPTY) begin
                        if (old_c == BLACK) rem_black <= 1'b1;
                        else                rem_white <= 1'b1;
                    end
                    if (old_c != EMPTY && new_c != EMPTY && new_c != old_c) overwrite <= 1'b1;
                    rx_sh  <= rx_sh  >> 2;
                    brd_sh <= brd_sh >> 2;
                    idx    <= idx + 7'd1;
                    if (idx == 7'(CELLS - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    if (bad_enc) begin
                        pkt_err_r <= 1'b1;
                        err_r     <= ENC;
                    end else if (overwrite || add_cnt == 2'd2 ||
                                 (add_cnt == 2'd0 && (rem_black || rem_white))) begin
                        pkt_err_r <= 1'b1;
                        err_r     <= ADD;
                    end else if ((add_col == BLACK && rem_black) ||
                                 (add_col == WHITE && rem_white)) begin
                        // A player never captures their own stones.
                        pkt_err_r <= 1'b1;
                        err_r     <= REM;
                    end else if (add_cnt == 2'd1) begin
                        move_avail_r <= 1'b1;
                        move_r       <= add_idx;
                        move_col_r   <= add_col;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (start_pend) pend_vld <= 1'b0;
            if (bus.rx_ready && state != S_IDLE) begin
                pend_dat <= bus.rx_bus;
                pend_vld <= 1'b1;
            end

            if (start_rx || start_pend) begin
                rx_sh     <= start_rx ? bus.rx_bus : pend_dat;
                brd_sh    <= bus.board_bus;
                idx       <= '0;
                add_cnt   <= '0;
                add_idx   <= '0;
                add_col   <= EMPTY;
                bad_enc   <= 1'b0;
                overwrite <= 1'b0;
                rem_black <= 1'b0;
                rem_white <= 1'b0;
                state     <= S_SCAN;
            end
        end
    end

    assign bus.move_avail = move_avail_r;
    assign bus.pkt_err    = pkt_err_r;
    assign bus.move       = move_r;
    assign bus.move_color = move_col_r;
    assign bus.err_code   = err_r;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_move_extractor.sv
// Scoreboarded bench for move_extractor: expected results queued at send time, checked when pulses appear.
// Latency: checks the fixed 83-cycle result timing and the 82-cycle chained pending timing.
// Backpressure: exercises the single latest-wins pending slot and mid-scan reset.
module tb_move_extractor;
    import board_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    move_extractor_if bus();

    move_extractor dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] mv;
        logic [1:0] col;
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   pulse_cnt = 0;

    always @(posedge clk_in) cyc++;

    // Result monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (bus.move_avail && bus.pkt_err) begin
            checks++;
            failures++;
            $display("FAIL both_pulses cyc=%0d move_avail=1 pkt_err=1 required never together", cyc);
        end
        if (bus.move_avail || bus.pkt_err) begin
            pulse_cnt++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d move_avail=%b pkt_err=%b move=%0d required no pulse",
                         cyc, bus.move_avail, bus.pkt_err, bus.move);
            end else begin
                e = q.pop_front();
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL latency got_cyc=%0d required_cyc=%0d", cyc, e.cyc);
                end
                checks++;
                if (bus.pkt_err !== e.is_err) begin
                    failures++;
                    $display("FAIL kind pkt_err=%b required=%b", bus.pkt_err, e.is_err);
                end
                if (e.is_err) begin
                    checks++;
                    if (bus.err_code !== e.code) begin
                        failures++;
                        $display("FAIL err_code got=%0d required=%0d", bus.err_code, e.code);
                    end
                end else begin
                    checks++;
                    if ({bus.move, bus.move_color} !== {e.mv, e.col}) begin
                        failures++;
                        $display("FAIL move got=%0d/%0d required=%0d/%0d",
                                 bus.move, bus.move_color, e.mv, e.col);
                    end
                end
            end
        end
    end

    function automatic logic [161:0] put(input logic [161:0] b, input int i, input logic [1:0] v);
        logic [161:0] r;
        r = b;
        r[2*i +: 2] = v;
        return r;
    endfunction

    task automatic send(input logic [161:0] rx, input logic [161:0] brd, output int c);
        @(negedge clk_in);
        bus.rx_bus    = rx;
        bus.board_bus = brd;
        bus.rx_ready  = 1'b1;
        c = cyc;
        @(negedge clk_in);
        bus.rx_ready = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk_in);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending_results=%0d required=0", name, q.size());
        end
        q.delete();
        repeat (5) @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in        = 1'b0;
        bus.rx_ready  = 1'b0;
        bus.rx_bus    = '0;
        bus.board_bus = '0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({bus.move_avail, bus.pkt_err, bus.busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b required=000", {bus.move_avail, bus.pkt_err, bus.busy});
        end
        checks++;
        if ({bus.move, bus.move_color, bus.err_code} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs move=%0d col=%0d err=%0d required 0/0/0",
                     bus.move, bus.move_color, bus.err_code);
        end
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_single_add();
        int c;
        send(put('0, 40, 2'b01), '0, c);
        q.push_back('{1'b0, 8'd40, 2'b01, 2'd0, c + 83});
        // Board changes after scan start must not affect this scan.
        bus.board_bus = '1;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_rise got=%b required=1", bus.busy);
        end
        while (cyc < c + 83) @(negedge clk_in);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_fall got=%b required=0", bus.busy);
        end
        wait_drain("single_add");
        bus.board_bus = '0;
    endtask

    task automatic test_capture();
        int c;
        send(put('0, 1, 2'b01), put('0, 0, 2'b10), c);
        q.push_back('{1'b0, 8'd1, 2'b01, 2'd0, c + 83});
        wait_drain("capture");
    endtask

    task automatic test_bad_enc();
        int c;
        send(put(put('0, 80, 2'b11), 10, 2'b10), '0, c);
        q.push_back('{1'b1, 8'd0, 2'b00, 2'd1, c + 83});
        wait_drain("bad_enc");
    endtask

    task automatic test_add_errors();
        int c;
        send(put(put('0, 3, 2'b01), 5, 2'b01), '0, c);
        q.push_back('{1'b1, 8'd0, 2'b00, 2'd2, c + 83});
        wait_drain("double_add");
        send(put('0, 4, 2'b10), put('0, 4, 2'b01), c);
        q.push_back('{1'b1, 8'd0, 2'b00, 2'd2, c + 83});
        wait_drain("overwrite");
        send('0, put('0, 4, 2'b01), c);
        q.push_back('{1'b1, 8'd0, 2'b00, 2'd2, c + 83});
        wait_drain("removal_only");
    endtask

    task automatic test_bad_removal();
        int c;
        send(put('0, 9, 2'b01), put('0, 7, 2'b01), c);
        q.push_back('{1'b1, 8'd0, 2'b00, 2'd3, c + 83});
        wait_drain("bad_removal");
    endtask

    task automatic test_no_change();
        int c;
        int pc;
        logic [161:0] b;
        b  = put(put('0, 2, 2'b01), 60, 2'b10);
        pc = pulse_cnt;
        send(b, b, c);
        while (cyc < c + 100) @(negedge clk_in);
        checks++;
        if (pulse_cnt !== pc) begin
            failures++;
            $display("FAIL no_change_pulses got=%0d required=%0d", pulse_cnt - pc, 0);
        end
        checks++;
        if ({bus.move, bus.move_color, bus.err_code, bus.busy} !== {8'd1, 2'b01, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL held_outputs move=%0d col=%0d err=%0d busy=%b required 1/1/3/0",
                     bus.move, bus.move_color, bus.err_code, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int c2;
        send(put('0, 10, 2'b01), '0, c);
        q.push_back('{1'b0, 8'd10, 2'b01, 2'd0, c + 83});
        while (cyc < c + 9) @(negedge clk_in);
        send(put('0, 20, 2'b10), '0, c2);
        while (cyc < c + 19) @(negedge clk_in);
        send(put('0, 30, 2'b10), '0, c2);
        q.push_back('{1'b0, 8'd30, 2'b10, 2'd0, c + 165});
        while (cyc < c + 83) @(negedge clk_in);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL chained_busy got=%b required=1", bus.busy);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_mid_reset();
        int c;
        send(put('0, 50, 2'b01), '0, c);
        while (cyc < c + 40) @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        checks++;
        if ({bus.move_avail, bus.pkt_err, bus.busy} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_flags got=%b required=000", {bus.move_avail, bus.pkt_err, bus.busy});
        end
        checks++;
        if ({bus.move, bus.move_color, bus.err_code} !== 12'h000) begin
            failures++;
            $display("FAIL midreset_outputs move=%0d col=%0d err=%0d required 0/0/0",
                     bus.move, bus.move_color, bus.err_code);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (100) @(negedge clk_in);
        send(put('0, 77, 2'b10), '0, c);
        q.push_back('{1'b0, 8'd77, 2'b10, 2'd0, c + 83});
        wait_drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_capture();
        test_bad_enc();
        test_add_errors();
        test_bad_removal();
        test_no_change();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
